debouncer_multi: RTL
====================

// Module: debouncer_multi
// PURPOSE
//  - N-channel parametrised debouncer for the alarm-clock push-buttons; successor to the fixed 5-input debouncer.
//  - Per channel: 2-flop synchroniser, stable-count filter, one-cycle press/release pulses, and long-press
//    detection with auto-repeat, used for fast time/alarm setting.
//  - Sits between the raw button pins and the clock/alarm control FSM.
// PARAMETERS
//  - N_CH           5    number of independent button channels (>=1)
//  - STABLE_CYCLES  4    consecutive synchronised samples needed to accept a new level (>=1; 40 ms at 10 ms clk)
//  - HOLD_CYCLES    100  cycles q must stay high before the first long-press pulse (>=1; 1 s)
//  - REPEAT_CYCLES  20   cycles between auto-repeat pulses after hold; 0 = repeat disabled
// PORTS
//  - clk        in   1     system clock, rising edge
//  - rst_n      in   1     asynchronous active-low reset
//  - din        in   N_CH  raw, asynchronous, bouncy button levels (1 = pressed)
//  - q          out  N_CH  debounced level
//  - press      out  N_CH  one-cycle pulse on accepted 0->1 of q
//  - release    out  N_CH  one-cycle pulse on accepted 1->0 of q
//  - hold       out  N_CH  one-cycle pulse: first at hold threshold, then on each auto-repeat
// BEHAVIOUR
//  - Reset (async, rst_n=0): sync flops, counters, q, press, release, hold all 0 immediately.
//    Idle level is 0. First sample is taken on the first rising clk after rst_n deasserts.
//  - Synchroniser: s = din delayed two clk edges; s is the only filter input.
//  - Stable counter cnt[i], width $clog2(STABLE_CYCLES+1):
//      s==q               -> cnt<=0
//      s!=q, cnt<STABLE-1 -> cnt<=cnt+1
//      s!=q, cnt==STABLE-1 -> q<=s, cnt<=0
//  - Any glitch back to the q level before acceptance clears cnt; no partial credit.
//  - Latency: din steady from edge k -> q changes at edge k+2+STABLE_CYCLES-1, i.e. q visible
//    2+STABLE_CYCLES cycles after the change.
//  - press/release: registered, asserted for exactly the cycle in which the new q is first visible.
//    Mutually exclusive per channel.
//  - Hold counter hcnt[i], width $clog2(max(HOLD,REPEAT)+1):
//      - Cleared while q==0 and on the press cycle; increments while q==1.
//      - When hcnt reaches HOLD_CYCLES: hold pulses, enter repeat phase, hcnt<=0.
//      - In repeat phase (REPEAT>0): hold pulses every REPEAT_CYCLES cycles while q==1.
//      - REPEAT_CYCLES==0: single hold pulse, hcnt saturates, no further pulses.
//  - Release during hold/repeat: no hold in that cycle; release pulses; repeat phase and hcnt clear.
//  - Channels fully independent; simultaneous events on several channels all reported in the same cycle.
//  - Reset mid-bounce or mid-hold: all state dropped asynchronously; no release pulse generated.
//  - No combinational path din->outputs; all outputs come straight from flops.
// STRUCTURE
//  - debounce_pkg: function cnt_w(n) = $clog2(n+1); localparam defaults for the 10 ms tick
//    (STABLE 4, HOLD 100, REPEAT 20) shared with the control FSM.
//  - Sub-module debounce_channel (one bit: sync, cnt, hcnt, q and pulse regs), instantiated N_CH times
//    in a generate loop. Top is wiring only.
// TESTING (defaults, 10 ms clk)
//  - Reset: rst_n=0 with din=5'h1F -> all outputs 0.
//    Release reset, hold din=5'h1F -> q=5'h1F and press=5'h1F for one cycle, 6 cycles after the first edge.
//  - Bounce: ch0 toggles every cycle for 10 cycles, then steady 1 -> exactly one press, 6 cycles after last
//    toggle. Glitch of 3 cycles on ch1 -> no q change, no pulses.
//  - Release: ch2 held then din->0 for 4+ cycles -> q falls and release pulses once; press never coincides.
//  - Long press: ch3 high 150 cycles after press ->
//      - hold at press+100 cycles, then at +120, +140;
//      - release at +150 -> release pulse, no further hold.
//  - REPEAT_CYCLES=0 build: ch0 held 300 cycles -> exactly one hold pulse at press+100.
//  - Async reset at press+110 during repeat -> all outputs 0 within same cycle, no release;
//    after deassert with din=1 -> fresh press after 6 cycles.
//  - Channel independence: random bouncy stimulus on all 5 channels vs. per-bit reference model;
//    q, press, release, hold must match cycle-exact.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared debounce types, width helper and default timing for the 10 ms button tick.
// The same defaults are used by the clock/alarm control FSM.
package debounce_pkg;

  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 100;
  localparam int DEF_REPEAT_CYCLES = 20;

  typedef enum logic [1:0] {
    HP_IDLE   = 2'd0,
    HP_WAIT   = 2'd1,
    HP_REPEAT = 2'd2
  } hold_phase_t;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, stable-count filter, press/release pulses,
// long-press detection with optional auto-repeat.
//
//   state     | meaning
//   HP_IDLE   | q low, hold counter parked at zero
//   HP_WAIT   | q high, counting towards the first long-press pulse
//   HP_REPEAT | threshold passed, pulsing every REPEAT_CYCLES (or silent if 0)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam int CW = cnt_w(STABLE_CYCLES);
  localparam int HW = cnt_w(max_int(HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic          s1, s2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  hold_phase_t   ph, ph_nxt;
  logic          q_nxt, press_nxt, rel_nxt, hold_nxt;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      hcnt  <= '0;
      ph    <= HP_IDLE;
      q     <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      hold  <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      cnt   <= cnt_nxt;
      hcnt  <= hcnt_nxt;
      ph    <= ph_nxt;
      q     <= q_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
      hold  <= hold_nxt;
    end
  end

  always_comb begin
    cnt_nxt   = cnt;
    q_nxt     = q;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    hold_nxt  = 1'b0;
    hcnt_nxt  = hcnt;
    ph_nxt    = ph;
    accept    = 1'b0;

    // Any sample matching q wipes the run; acceptance needs an unbroken run.
    if (s2 == q) begin
      cnt_nxt = '0;
    end else if (cnt == STABLE_LAST) begin
      accept    = 1'b1;
      q_nxt     = s2;
      cnt_nxt   = '0;
      press_nxt = s2;
      rel_nxt   = ~s2;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end

    // In WAIT/REPEAT q is high, so an accept there is always a release and wins over hold.
    case (ph)
      HP_IDLE: begin
        hcnt_nxt = '0;
        if (accept && s2) ph_nxt = HP_WAIT;
      end
      HP_WAIT: begin
        if (accept) begin
          ph_nxt   = HP_IDLE;
          hcnt_nxt = '0;
        end else if (hcnt == HOLD_LAST) begin
          hold_nxt = 1'b1;
          hcnt_nxt = '0;
          ph_nxt   = HP_REPEAT;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      HP_REPEAT: begin
        if (accept) begin
          ph_nxt   = HP_IDLE;
          hcnt_nxt = '0;
        end else if (REPEAT_CYCLES == 0) begin
          hcnt_nxt = hcnt;
        end else if (hcnt == REPEAT_LAST) begin
          hold_nxt = 1'b1;
          hcnt_nxt = '0;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      default: begin
        ph_nxt   = HP_IDLE;
        hcnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/debouncer_multi.sv
// N-channel push-button debouncer; wiring only, one debounce_channel per button.
// The release pulse port is named rel because release is a reserved word.
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 5,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] q,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] hold
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din[i]),
      .q     (q[i]),
      .press (press[i]),
      .rel   (rel[i]),
      .hold  (hold[i])
    );
  end

endmodule
